// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants and types for the skid-buffered pipeline stage register.
package pipe_stage_skid_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_REG_W  = 5;

    typedef enum logic [1:0] {
        ENT_HOLD  = 2'd0,
        ENT_LOAD  = 2'd1,
        ENT_CLEAR = 2'd2,
        ENT_INVAL = 2'd3
    } entry_op_e;

    function automatic logic [1:0] count_entries(input logic v0, input logic v1);
        return {1'b0, v0} + {1'b0, v1};
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage slot: a valid bit plus the A/B/R fields.
// CLEAR drops valid and zeroes the data; INVAL drops valid only.
module pipe_entry
    import pipe_stage_skid_pkg::*;
#(
    parameter int W_A = PIPE_DATA_W,
    parameter int W_B = PIPE_DATA_W,
    parameter int W_R = PIPE_REG_W
) (
    input  logic           clock,
    input  logic           reset,
    input  entry_op_e      op,
    input  logic [W_A-1:0] in_a,
    input  logic [W_B-1:0] in_b,
    input  logic [W_R-1:0] in_r,
    output logic           valid,
    output logic [W_A-1:0] a,
    output logic [W_B-1:0] b,
    output logic [W_R-1:0] r
);

    // Slot state update: reset, then the operation chosen by the steering logic
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            a     <= {W_A{1'b0}};
            b     <= {W_B{1'b0}};
            r     <= {W_R{1'b0}};
        end else begin
            case (op)
                ENT_LOAD: begin
                    valid <= 1'b1;
                    a     <= in_a;
                    b     <= in_b;
                    r     <= in_r;
                end
                ENT_CLEAR: begin
                    valid <= 1'b0;
                    a     <= {W_A{1'b0}};
                    b     <= {W_B{1'b0}};
                    r     <= {W_R{1'b0}};
                end
                ENT_INVAL: valid <= 1'b0;
                ENT_HOLD:  valid <= valid;
                default:   valid <= valid;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, one-entry skid buffer
// and synchronous flush. in_ready is registered so no input reaches it combinationally.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int W_A       = PIPE_DATA_W,
    parameter int W_B       = PIPE_DATA_W,
    parameter int W_R       = PIPE_REG_W,
    parameter bit FLUSH_CLR = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W_A-1:0] in_a,
    input  logic [W_B-1:0] in_b,
    input  logic [W_R-1:0] in_r,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W_A-1:0] out_a,
    output logic [W_B-1:0] out_b,
    output logic [W_R-1:0] out_r,
    output logic [1:0]     occupancy
);

    logic           main_valid_s;
    logic           skid_valid_s;
    logic [W_A-1:0] skid_a_s;
    logic [W_B-1:0] skid_b_s;
    logic [W_R-1:0] skid_r_s;
    logic [W_A-1:0] main_in_a_s;
    logic [W_B-1:0] main_in_b_s;
    logic [W_R-1:0] main_in_r_s;
    entry_op_e      main_op_s;
    entry_op_e      skid_op_s;
    logic           main_from_skid_s;
    logic           main_v_nxt_s;
    logic           skid_v_nxt_s;
    logic           acc_s;
    logic           dep_s;
    logic           in_ready_r;
    logic [1:0]     occupancy_r;

    assign acc_s     = in_valid & in_ready_r;
    assign dep_s     = main_valid_s & out_ready;
    assign in_ready  = in_ready_r;
    assign occupancy = occupancy_r;
    assign out_valid = main_valid_s;

    // Steering: decide what each slot does this cycle and the resulting valid bits
    always_comb begin
        main_op_s        = ENT_HOLD;
        skid_op_s        = ENT_HOLD;
        main_from_skid_s = 1'b0;
        main_v_nxt_s     = main_valid_s;
        skid_v_nxt_s     = skid_valid_s;
        if (flush) begin
            if (FLUSH_CLR) begin
                main_op_s = ENT_CLEAR;
                skid_op_s = ENT_CLEAR;
            end else begin
                main_op_s = ENT_INVAL;
                skid_op_s = ENT_INVAL;
            end
            main_v_nxt_s = 1'b0;
            skid_v_nxt_s = 1'b0;
        end else if (!main_valid_s) begin
            if (acc_s) begin
                main_op_s    = ENT_LOAD;
                main_v_nxt_s = 1'b1;
            end else begin
                main_op_s = ENT_HOLD;
            end
        end else if (dep_s) begin
            // Skid content is older than anything on the input, so it goes first
            if (skid_valid_s) begin
                main_op_s        = ENT_LOAD;
                main_from_skid_s = 1'b1;
                skid_op_s        = ENT_CLEAR;
                skid_v_nxt_s     = 1'b0;
            end else if (acc_s) begin
                main_op_s = ENT_LOAD;
            end else begin
                main_op_s    = ENT_INVAL;
                main_v_nxt_s = 1'b0;
            end
        end else if (acc_s) begin
            skid_op_s    = ENT_LOAD;
            skid_v_nxt_s = 1'b1;
        end else begin
            main_op_s = ENT_HOLD;
            skid_op_s = ENT_HOLD;
        end
    end

    // Main slot source: skid when draining it, otherwise the upstream fields
    always_comb begin
        if (main_from_skid_s) begin
            main_in_a_s = skid_a_s;
            main_in_b_s = skid_b_s;
            main_in_r_s = skid_r_s;
        end else begin
            main_in_a_s = in_a;
            main_in_b_s = in_b;
            main_in_r_s = in_r;
        end
    end

    // Handshake status registers derived from next-cycle slot validity
    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready_r  <= 1'b1;
            occupancy_r <= 2'd0;
        end else begin
            in_ready_r  <= ~skid_v_nxt_s;
            occupancy_r <= count_entries(main_v_nxt_s, skid_v_nxt_s);
        end
    end

    pipe_entry #(.W_A(W_A), .W_B(W_B), .W_R(W_R)) u_main (
        .clock (clock),
        .reset (reset),
        .op    (main_op_s),
        .in_a  (main_in_a_s),
        .in_b  (main_in_b_s),
        .in_r  (main_in_r_s),
        .valid (main_valid_s),
        .a     (out_a),
        .b     (out_b),
        .r     (out_r)
    );

    pipe_entry #(.W_A(W_A), .W_B(W_B), .W_R(W_R)) u_skid (
        .clock (clock),
        .reset (reset),
        .op    (skid_op_s),
        .in_a  (in_a),
        .in_b  (in_b),
        .in_r  (in_r),
        .valid (skid_valid_s),
        .a     (skid_a_s),
        .b     (skid_b_s),
        .r     (skid_r_s)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a scoreboard queue models the held entries
// and every cycle compares occupancy, handshake and output fields against it.
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  r;
    } item_t;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_r;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_r;
    logic [1:0]  occupancy;

    int    checks;
    int    failures;
    int    delivered;
    item_t sb_q[$];

    pipe_stage_skid dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_r      (in_r),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_r     (out_r),
        .occupancy (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare DUT against the scoreboard, update the model, then advance one clock
    task automatic tick();
        int    sz;
        bit    acc;
        bit    dep;
        item_t it;
        if (!reset) begin
            sz = sb_q.size();
            check("occupancy", 32'(occupancy), 32'(sz));
            check("in_ready", 32'(in_ready), 32'(sz < 2));
            check("out_valid", 32'(out_valid), 32'(sz != 0));
            if (sz != 0) begin
                check("out_a", out_a, sb_q[0].a);
                check("out_b", out_b, sb_q[0].b);
                check("out_r", 32'(out_r), 32'(sb_q[0].r));
            end
            acc = in_valid && (sz < 2);
            dep = (sz != 0) && out_ready;
            if (dep) begin
                void'(sb_q.pop_front());
                delivered++;
            end
            if (flush) begin
                sb_q.delete();
            end else if (acc) begin
                it.a = in_a;
                it.b = in_b;
                it.r = in_r;
                sb_q.push_back(it);
            end
        end else begin
            sb_q.delete();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a);
        in_valid = v;
        in_a     = a;
        in_b     = ~a;
        in_r     = a[4:0] ^ 5'h15;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_a"}, out_a, 32'd0);
        check({tag, "_out_b"}, out_b, 32'd0);
        check({tag, "_out_r"}, 32'(out_r), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        delivered = 0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0);

        // Reset held two cycles with random inputs
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'($urandom);
            in_a      = $urandom;
            in_b      = $urandom;
            in_r      = 5'($urandom);
            flush     = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        check_reset_values("reset");
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0);
        tick();

        // Streaming 1..8 back to back
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i));
            tick();
        end
        drive(1'b0, 32'd0);
        tick();
        tick();
        check("stream_delivered", 32'(delivered), 32'd8);

        // Stall: two entries pile up, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'h11);
        tick();
        drive(1'b1, 32'h22);
        tick();
        drive(1'b1, 32'h99);
        tick();
        check("stall_occ2", 32'(occupancy), 32'd2);
        check("stall_hold_a", out_a, 32'h11);
        drive(1'b0, 32'd0);
        tick();
        out_ready = 1'b1;
        tick();
        check("stall_second_a", out_a, 32'h22);
        check("stall_ready_back", 32'(in_ready), 32'd1);
        tick();
        tick();

        // Flush with two held entries and an input offered
        out_ready = 1'b0;
        drive(1'b1, 32'h44);
        tick();
        drive(1'b1, 32'h45);
        tick();
        drive(1'b1, 32'h33);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_zero_a", out_a, 32'd0);
        out_ready = 1'b1;
        tick();
        tick();

        // Flush with one held entry while an input is accepted the same cycle
        out_ready = 1'b0;
        drive(1'b1, 32'h70);
        tick();
        drive(1'b1, 32'h71);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0);
        out_ready = 1'b1;
        tick();
        tick();

        // Flush and departure in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 32'h55);
        tick();
        drive(1'b1, 32'h66);
        tick();
        drive(1'b0, 32'd0);
        delivered = 0;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        check("flush_dep_count", 32'(delivered), 32'd1);

        // Reset beats flush while both entries are held
        out_ready = 1'b0;
        drive(1'b1, 32'hA1);
        tick();
        drive(1'b1, 32'hA2);
        tick();
        drive(1'b1, 32'hA3);
        reset = 1'b1;
        flush = 1'b1;
        tick();
        check_reset_values("reset_mid");
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'd0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
